// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I-fetch (read) and D-access (r/w).
// Ports: clk_i/rst_i; i_* fetch side; d_* data side; mem_* registered memory side.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_err_o,
  output logic              i_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] timeout_cnt;

  logic i_eff;
  logic d_eff;
  logic starved;
  logic grant_d;
  logic grant_i;
  logic timed_out;
  logic done;
  logic [DATA_W-1:0] rdata;

  // A requester in its ack cycle is masked so a held
  // request is not granted twice.
  assign i_eff = i_req_i & ~i_ack_o;
  assign d_eff = d_req_i & ~d_ack_o;

  assign starved = i_eff &&
    (starve_cnt == SW'(STARVE_MAX));
  assign grant_d = d_eff & ~starved;
  assign grant_i = i_eff & ~grant_d;

  assign timed_out = timeout_cnt == TW'(TIMEOUT - 1);
  assign done      = mem_ack_i | timed_out;

  // Ack beats timeout; writes and timeouts return zero.
  assign rdata = (mem_ack_i && !mem_we_o) ?
    mem_rdata_i : '0;

  assign i_stall_o = i_req_i & ~i_ack_o;
  assign d_stall_o = d_req_i & ~d_ack_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      timeout_cnt <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      i_ack_o     <= 1'b0;
      i_rdata_o   <= '0;
      i_err_o     <= 1'b0;
      d_ack_o     <= 1'b0;
      d_rdata_o   <= '0;
      d_err_o     <= 1'b0;
    end else begin
      i_ack_o   <= 1'b0;
      i_rdata_o <= '0;
      i_err_o   <= 1'b0;
      d_ack_o   <= 1'b0;
      d_rdata_o <= '0;
      d_err_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grant_d: begin
              state       <= BUSY_D;
              mem_req_o   <= 1'b1;
              mem_we_o    <= d_we_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
              timeout_cnt <= '0;
              if (!i_eff)
                starve_cnt <= '0;
              else if (starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
            end
            grant_i: begin
              state       <= BUSY_I;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= i_addr_i;
              mem_wdata_o <= '0;
              timeout_cnt <= '0;
              starve_cnt  <= '0;
            end
            default: ;
          endcase
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            if (state == BUSY_D) begin
              d_ack_o   <= 1'b1;
              d_err_o   <= ~mem_ack_i;
              d_rdata_o <= rdata;
            end else begin
              i_ack_o   <= 1'b1;
              i_err_o   <= ~mem_ack_i;
              i_rdata_o <= rdata;
            end
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model + directed and random stimulus.
// Outputs are compared against the model every cycle on the falling edge.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic          i_ack_o;
  logic [DW-1:0] i_rdata_o;
  logic          i_err_o;
  logic          i_stall_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_ack_o;
  logic [DW-1:0] d_rdata_o;
  logic          d_err_o;
  logic          d_stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .STARVE_MAX(SMAX), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i),
    .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
    .i_err_o(i_err_o), .i_stall_o(i_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .d_err_o(d_err_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic          mreq;
    logic          mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic          iack;
    logic          ierr;
    logic [DW-1:0] irdata;
    logic          dack;
    logic          derr;
    logic [DW-1:0] drdata;
  } exp_t;

  exp_t  e;
  bit    model_ok = 1'b0;
  bit    busy;
  bit    own_d;
  int    cyc = 0;
  int    deadline;
  int    starve;
  bit    glog[$];

  // One outstanding transaction at a time: it is opened by a
  // grant, closed by the first memory ack or by the deadline
  // TO cycles after the grant, whichever comes first.
  always @(posedge clk) begin : model
    bit iw, dw, late;
    cyc = cyc + 1;
    if (rst_i) begin
      busy = 1'b0;
      starve = 0;
      e.mreq = 1'b0; e.mwe = 1'b0;
      e.maddr = '0; e.mwdata = '0;
      e.iack = 1'b0; e.ierr = 1'b0; e.irdata = '0;
      e.dack = 1'b0; e.derr = 1'b0; e.drdata = '0;
      model_ok = 1'b1;
    end else begin
      iw = i_req_i && !e.iack;
      dw = d_req_i && !e.dack;
      e.iack = 1'b0; e.ierr = 1'b0; e.irdata = '0;
      e.dack = 1'b0; e.derr = 1'b0; e.drdata = '0;
      if (busy) begin
        late = (cyc >= deadline);
        if (mem_ack_i || late) begin
          busy = 1'b0;
          e.mreq = 1'b0;
          if (own_d) begin
            e.dack = 1'b1;
            e.derr = !mem_ack_i;
            e.drdata = (mem_ack_i && !e.mwe) ? mem_rdata_i : '0;
          end else begin
            e.iack = 1'b1;
            e.ierr = !mem_ack_i;
            e.irdata = mem_ack_i ? mem_rdata_i : '0;
          end
        end
      end else if (dw && !(iw && starve == SMAX)) begin
        busy = 1'b1; own_d = 1'b1;
        deadline = cyc + TO;
        e.mreq = 1'b1; e.mwe = d_we_i;
        e.maddr = d_addr_i; e.mwdata = d_wdata_i;
        starve = iw ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        glog.push_back(1'b1);
      end else if (iw) begin
        busy = 1'b1; own_d = 1'b0;
        deadline = cyc + TO;
        e.mreq = 1'b1; e.mwe = 1'b0;
        e.maddr = i_addr_i; e.mwdata = '0;
        starve = 0;
        glog.push_back(1'b0);
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  function automatic void cmp(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h at t=%0t",
                  nm, act, exp, $time);
  endfunction

  function automatic void compare_all();
    if (!model_ok) return;
    cmp("mem_req", 32'(mem_req_o), 32'(e.mreq));
    if (e.mreq) begin
      cmp("mem_we", 32'(mem_we_o), 32'(e.mwe));
      cmp("mem_addr", mem_addr_o, e.maddr);
      cmp("mem_wdata", mem_wdata_o, e.mwdata);
    end
    cmp("i_ack", 32'(i_ack_o), 32'(e.iack));
    cmp("i_err", 32'(i_err_o), 32'(e.ierr));
    cmp("i_rdata", i_rdata_o, e.irdata);
    cmp("d_ack", 32'(d_ack_o), 32'(e.dack));
    cmp("d_err", 32'(d_err_o), 32'(e.derr));
    cmp("d_rdata", d_rdata_o, e.drdata);
    cmp("i_stall", 32'(i_stall_o), 32'(i_req_i & ~e.iack));
    cmp("d_stall", 32'(d_stall_o), 32'(d_req_i & ~e.dack));
  endfunction

  // ---------------- memory responder ----------------
  // mode 0: random acks (also stray acks while idle)
  // mode 1: ack mem_lat cycles after mem_req_o rises
  // mode 2: silent
  int            mem_mode = 0;
  int            mem_lat  = 0;
  int            ack_pct  = 30;
  logic [DW-1:0] mem_data = '0;
  int            hc = 0;
  bit            prev_req = 1'b0;

  task automatic mem_drive();
    mem_ack_i = 1'b0;
    mem_rdata_i = $urandom;
    if (mem_req_o) hc = prev_req ? hc + 1 : 0;
    prev_req = mem_req_o;
    case (mem_mode)
      0: begin
        if (mem_req_o)
          mem_ack_i = ($urandom_range(0, 99) < ack_pct);
        else
          mem_ack_i = ($urandom_range(0, 99) < 4);
      end
      1: begin
        if (mem_req_o && hc == mem_lat) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_data;
        end
      end
      default: ;
    endcase
  endtask

  // Compare on the falling edge, then drive for the current cycle.
  task automatic tick();
    @(negedge clk);
    compare_all();
    #1;
    mem_drive();
  endtask

  int            hi;
  int            rises;
  bit            seen;
  bit            last_req;
  logic          r_err;
  logic [DW-1:0] r_data;
  logic [AW-1:0] gaddr[$];
  logic [AW-1:0] exp_addr[6];
  bit            exp_g[6];
  int            pcts[6];

  initial begin
    rst_i = 1'b1;
    i_req_i = 1'b0; i_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (3) tick();
    cmp("rst_mem_req", 32'(mem_req_o), 32'd0);
    cmp("rst_mem_addr", mem_addr_o, 32'd0);
    cmp("rst_i_ack", 32'(i_ack_o), 32'd0);
    cmp("rst_d_rdata", d_rdata_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // single I read, memory acks one cycle after mem_req_o
    mem_mode = 1; mem_lat = 1; mem_data = 32'hDEADBEEF;
    i_req_i = 1'b1; i_addr_i = 32'h40;
    tick();
    cmp("t1_mem_req_c1", 32'(mem_req_o), 32'd1);
    cmp("t1_mem_addr_c1", mem_addr_o, 32'h40);
    tick();
    tick();
    cmp("t1_i_ack_c3", 32'(i_ack_o), 32'd1);
    cmp("t1_i_rdata_c3", i_rdata_o, 32'hDEADBEEF);
    cmp("t1_i_err_c3", 32'(i_err_o), 32'd0);
    cmp("t1_i_stall_c3", 32'(i_stall_o), 32'd0);
    i_req_i = 1'b0;
    repeat (3) tick();

    // simultaneous I read and D write, memory acks at once
    mem_mode = 1; mem_lat = 0; mem_data = 32'hCAFE0001;
    d_req_i = 1'b1; d_we_i = 1'b1;
    d_addr_i = 32'h100; d_wdata_i = 32'h12345678;
    i_req_i = 1'b1; i_addr_i = 32'h40;
    tick();
    cmp("t2_mem_we_c1", 32'(mem_we_o), 32'd1);
    cmp("t2_mem_addr_c1", mem_addr_o, 32'h100);
    tick();
    cmp("t2_d_ack_c2", 32'(d_ack_o), 32'd1);
    cmp("t2_d_rdata_c2", d_rdata_o, 32'd0);
    d_req_i = 1'b0; d_we_i = 1'b0;
    tick();
    cmp("t2_mem_addr_c3", mem_addr_o, 32'h40);
    tick();
    cmp("t2_i_ack_c4", 32'(i_ack_o), 32'd1);
    cmp("t2_i_rdata_c4", i_rdata_o, 32'hCAFE0001);
    i_req_i = 1'b0;
    repeat (3) tick();

    // starvation: a held I request would win every D ack
    // cycle, so I is presented only in the cycles where D is
    // granted until the guard trips, then held to its ack.
    glog.delete();
    gaddr.delete();
    last_req = mem_req_o;
    mem_mode = 1; mem_lat = 0;
    d_we_i = 1'b0; d_addr_i = 32'h200; i_addr_i = 32'h300;
    for (int k = 0; k < 18; k++) begin
      i_req_i = (k < 12) ? (k % 3 == 0) : (k <= 14);
      d_req_i = (k < 16);
      tick();
      if (mem_req_o && !last_req) gaddr.push_back(mem_addr_o);
      last_req = mem_req_o;
    end
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_addr = '{32'h200, 32'h200, 32'h200,
                 32'h200, 32'h300, 32'h200};
    cmp("t3_model_grants", 32'(glog.size()), 32'd6);
    cmp("t3_dut_grants", 32'(gaddr.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < glog.size())
        cmp("t3_model_order", 32'(glog[k]), 32'(exp_g[k]));
      if (k < gaddr.size())
        cmp("t3_dut_order", gaddr[k], exp_addr[k]);
    end
    cmp("t3_starve_after_i", 32'(starve), 32'd0);
    i_req_i = 1'b0; d_req_i = 1'b0;
    repeat (2) tick();

    // timeout on a D read, then a late ack while idle
    mem_mode = 2;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500;
    hi = 0; seen = 1'b0; r_err = 1'b0; r_data = '1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (mem_req_o) hi = hi + 1;
      if (d_ack_o) begin
        seen = 1'b1; r_err = d_err_o; r_data = d_rdata_o;
        d_req_i = 1'b0;
        break;
      end
    end
    cmp("t4_ack_seen", 32'(seen), 32'd1);
    cmp("t4_req_cycles", 32'(hi), 32'd16);
    cmp("t4_err", 32'(r_err), 32'd1);
    cmp("t4_rdata", r_data, 32'd0);
    repeat (3) tick();
    mem_ack_i = 1'b1;
    tick();
    cmp("t4_late_d_ack", 32'(d_ack_o), 32'd0);
    cmp("t4_late_i_ack", 32'(i_ack_o), 32'd0);
    repeat (2) tick();

    // reset during BUSY_I, held request re-granted afterwards
    mem_mode = 2;
    i_req_i = 1'b1; i_addr_i = 32'h600;
    repeat (3) tick();
    cmp("t5_busy_before_rst", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    tick();
    cmp("t5_rst_mem_req", 32'(mem_req_o), 32'd0);
    cmp("t5_rst_mem_addr", mem_addr_o, 32'd0);
    cmp("t5_rst_i_ack", 32'(i_ack_o), 32'd0);
    rst_i = 1'b0;
    tick();
    cmp("t5_regrant", 32'(mem_req_o), 32'd1);
    cmp("t5_regrant_addr", mem_addr_o, 32'h600);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD0600;
    tick();
    cmp("t5_i_ack", 32'(i_ack_o), 32'd1);
    cmp("t5_i_rdata", i_rdata_o, 32'h0BAD0600);
    i_req_i = 1'b0;
    repeat (2) tick();

    // I held through its ack cycle, then dropped
    mem_mode = 1; mem_lat = 0;
    i_req_i = 1'b1; i_addr_i = 32'h700;
    rises = 0; seen = 1'b0; last_req = mem_req_o;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (mem_req_o && !last_req) rises = rises + 1;
      last_req = mem_req_o;
      if (i_ack_o) seen = 1'b1;
      else if (seen) i_req_i = 1'b0;
    end
    cmp("t6_ack_seen", 32'(seen), 32'd1);
    cmp("t6_single_issue", 32'(rises), 32'd1);

    // random traffic with varying memory responsiveness
    mem_mode = 0;
    pcts = '{40, 15, 70, 7, 25, 100};
    for (int b = 0; b < 6; b++) begin
      ack_pct = pcts[b];
      for (int n = 0; n < 500; n++) begin
        tick();
        rst_i = ($urandom_range(0, 399) == 0);
        if (i_req_i) begin
          if (i_ack_o) begin
            i_req_i = $urandom_range(0, 1);
            i_addr_i = $urandom;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          i_req_i = 1'b1;
          i_addr_i = $urandom;
        end
        if (d_req_i) begin
          if (d_ack_o) begin
            d_req_i = $urandom_range(0, 1);
            d_we_i = $urandom_range(0, 1);
            d_addr_i = $urandom;
            d_wdata_i = $urandom;
          end
        end else if ($urandom_range(0, 1) == 0) begin
          d_req_i = 1'b1;
          d_we_i = $urandom_range(0, 1);
          d_addr_i = $urandom;
          d_wdata_i = $urandom;
        end
      end
    end
    rst_i = 1'b0;
    i_req_i = 1'b0; d_req_i = 1'b0;
    repeat (TO + 4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
